// File: rtl/systolic_array_v1_pkg.sv
// Shared sizing constants and sequencing states for the output-stationary
// systolic matrix multiplier.
package systolic_array_v1_pkg;

    localparam int ARRAY_N             = 4;
    localparam int ELEM_W              = 8;
    localparam int ACC_W               = 20;
    localparam int SYSTOLIC_DATA_WIDTH = ARRAY_N * ELEM_W;
    localparam int PROD_W              = 2 * ELEM_W;

    // Last operand pair reaches PE(N-1,N-1) 2N-2 cycles after its fire edge.
    localparam int DRAIN_CYCLES = 2 * ARRAY_N - 1;
    localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);
    localparam int ROW_W        = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DRAIN  = 2'd1,
        S_OUTPUT = 2'd2
    } arrState_e;

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: forwards a to the right and b downward through
// registers while accumulating the signed product into a wrapping accumulator.
module systolic_pe
    import systolic_array_v1_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [ELEM_W-1:0] aIn,
    input  logic signed [ELEM_W-1:0] bIn,
    output logic signed [ELEM_W-1:0] aOut,
    output logic signed [ELEM_W-1:0] bOut,
    output logic signed [ACC_W-1:0]  acc
);

    logic [PROD_W-1:0] aExt;
    logic [PROD_W-1:0] bExt;
    logic [PROD_W-1:0] prod;

    // The low PROD_W bits of the product of sign-extended operands are the
    // exact two's-complement product.
    assign aExt = {{ELEM_W{aIn[ELEM_W-1]}}, aIn};
    assign bExt = {{ELEM_W{bIn[ELEM_W-1]}}, bIn};
    assign prod = aExt * bExt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aOut <= '0;
            bOut <= '0;
            acc  <= '0;
        end else begin
            aOut <= aIn;
            bOut <= bIn;
            if (clr) begin
                acc <= '0;
            end else begin
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end
        end
    end

endmodule

// File: rtl/systolic_array_v1.sv
// N x N output-stationary systolic multiplier: skews A columns / B rows into a
// PE grid, drains the wavefront, then streams C out one row per handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_LOAD   | accept paired A/B beats; a beat with A done starts drain
//   S_DRAIN  | down-counter lets the last wavefront reach PE(N-1,N-1)
//   S_OUTPUT | present row r of the accumulators until the last row moves
module systolic_array_v1
    import systolic_array_v1_pkg::*;
(
    input  logic                           s_clk,
    input  logic                           s_rst,
    input  logic                           MtrxA_slice_valid,
    input  logic [SYSTOLIC_DATA_WIDTH-1:0] MtrxA_slice_data,
    input  logic                           MtrxA_slice_done,
    output logic                           MtrxA_slice_ready,
    input  logic                           MtrxB_slice_valid,
    input  logic [SYSTOLIC_DATA_WIDTH-1:0] MtrxB_slice_data,
    input  logic                           MtrxB_slice_done,
    output logic                           MtrxB_slice_ready,
    output logic                           MtrxC_slice_valid,
    output logic [ARRAY_N*ACC_W-1:0]       MtrxC_slice_data,
    output logic                           MtrxC_slice_done,
    input  logic                           MtrxC_slice_ready
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ROW_W-1:0]       LAST_ROW   = ROW_W'(ARRAY_N - 1);

    arrState_e                stateQ, stateD;
    logic [DRAIN_CNT_W-1:0]   drainCntQ, drainCntD;
    logic [ROW_W-1:0]         rowIdxQ, rowIdxD;
    logic [ROW_W-1:0]         rowSel;
    logic                     cValidD, cDoneD;
    logic [ARRAY_N*ACC_W-1:0] cDataD, rowVec;
    logic                     fire, accClr;

    logic signed [ELEM_W-1:0] aGrid   [ARRAY_N][ARRAY_N+1];
    logic signed [ELEM_W-1:0] bGrid   [ARRAY_N+1][ARRAY_N];
    logic signed [ACC_W-1:0]  accGrid [ARRAY_N][ARRAY_N];

    assign MtrxA_slice_ready = (stateQ == S_LOAD) & MtrxB_slice_valid;
    assign MtrxB_slice_ready = (stateQ == S_LOAD) & MtrxA_slice_valid;
    assign fire = (stateQ == S_LOAD) & MtrxA_slice_valid & MtrxB_slice_valid;

    // Row i / column i is delayed i cycles; non-fire cycles inject zeros.
    for (genvar i = 0; i < ARRAY_N; i++) begin : gSkew
        logic signed [ELEM_W-1:0] aFeed, bFeed;
        assign aFeed = fire ? MtrxA_slice_data[i*ELEM_W +: ELEM_W] : '0;
        assign bFeed = fire ? MtrxB_slice_data[i*ELEM_W +: ELEM_W] : '0;
        if (i == 0) begin : gDirect
            assign aGrid[0][0] = aFeed;
            assign bGrid[0][0] = bFeed;
        end else begin : gDelay
            logic signed [ELEM_W-1:0] aSh [i];
            logic signed [ELEM_W-1:0] bSh [i];
            always_ff @(posedge s_clk or posedge s_rst) begin
                if (s_rst) begin
                    for (int d = 0; d < i; d++) begin
                        aSh[d] <= '0;
                        bSh[d] <= '0;
                    end
                end else begin
                    aSh[0] <= aFeed;
                    bSh[0] <= bFeed;
                    for (int d = 1; d < i; d++) begin
                        aSh[d] <= aSh[d-1];
                        bSh[d] <= bSh[d-1];
                    end
                end
            end
            assign aGrid[i][0] = aSh[i-1];
            assign bGrid[0][i] = bSh[i-1];
        end
    end

    for (genvar i = 0; i < ARRAY_N; i++) begin : gRow
        for (genvar j = 0; j < ARRAY_N; j++) begin : gCol
            systolic_pe uPe (
                .clk  (s_clk),
                .rst  (s_rst),
                .clr  (accClr),
                .aIn  (aGrid[i][j]),
                .bIn  (bGrid[i][j]),
                .aOut (aGrid[i][j+1]),
                .bOut (bGrid[i+1][j]),
                .acc  (accGrid[i][j])
            );
        end
    end

    // Edge-of-grid pass-through outputs and B done have no consumer.
    logic unusedSink;
    always_comb begin
        unusedSink = MtrxB_slice_done;
        for (int k = 0; k < ARRAY_N; k++) begin
            unusedSink = unusedSink ^ (^aGrid[k][ARRAY_N]) ^ (^bGrid[ARRAY_N][k]);
        end
    end

    // First OUTPUT cycle loads row 0; afterwards each accepted row loads the next.
    assign rowSel = MtrxC_slice_valid ? (rowIdxQ + ROW_W'(1)) : rowIdxQ;

    always_comb begin
        rowVec = '0;
        for (int j = 0; j < ARRAY_N; j++) begin
            rowVec[j*ACC_W +: ACC_W] = accGrid[rowSel][j];
        end
    end

    always_comb begin
        stateD    = stateQ;
        drainCntD = drainCntQ;
        rowIdxD   = rowIdxQ;
        cValidD   = MtrxC_slice_valid;
        cDoneD    = MtrxC_slice_done;
        cDataD    = MtrxC_slice_data;
        accClr    = 1'b0;
        case (stateQ)
            S_LOAD: begin
                if (fire && MtrxA_slice_done) begin
                    stateD    = S_DRAIN;
                    drainCntD = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (drainCntQ == '0) begin
                    stateD = S_OUTPUT;
                end else begin
                    drainCntD = drainCntQ - DRAIN_CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (!MtrxC_slice_valid) begin
                    cValidD = 1'b1;
                    cDataD  = rowVec;
                    cDoneD  = (rowIdxQ == LAST_ROW);
                end else if (MtrxC_slice_ready) begin
                    if (rowIdxQ == LAST_ROW) begin
                        cValidD = 1'b0;
                        cDoneD  = 1'b0;
                        cDataD  = '0;
                        rowIdxD = '0;
                        accClr  = 1'b1;
                        stateD  = S_LOAD;
                    end else begin
                        rowIdxD = rowIdxQ + ROW_W'(1);
                        cDataD  = rowVec;
                        cDoneD  = (rowIdxD == LAST_ROW);
                    end
                end
            end
            default: stateD = S_LOAD;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            stateQ            <= S_LOAD;
            drainCntQ         <= '0;
            rowIdxQ           <= '0;
            MtrxC_slice_valid <= 1'b0;
            MtrxC_slice_done  <= 1'b0;
            MtrxC_slice_data  <= '0;
        end else begin
            stateQ            <= stateD;
            drainCntQ         <= drainCntD;
            rowIdxQ           <= rowIdxD;
            MtrxC_slice_valid <= cValidD;
            MtrxC_slice_done  <= cDoneD;
            MtrxC_slice_data  <= cDataD;
        end
    end

endmodule

// File: tb/tb_systolic_array_v1.sv
// Scoreboard bench for systolic_array_v1: directed matrices with hand-computed
// C rows queued at issue time and checked by an independent row monitor.
module tb_systolic_array_v1;
    import systolic_array_v1_pkg::*;

    localparam int CW = ARRAY_N * ACC_W;

    logic                           s_clk = 1'b0;
    logic                           s_rst;
    logic                           MtrxA_slice_valid, MtrxA_slice_done, MtrxA_slice_ready;
    logic [SYSTOLIC_DATA_WIDTH-1:0] MtrxA_slice_data;
    logic                           MtrxB_slice_valid, MtrxB_slice_done, MtrxB_slice_ready;
    logic [SYSTOLIC_DATA_WIDTH-1:0] MtrxB_slice_data;
    logic                           MtrxC_slice_valid, MtrxC_slice_done, MtrxC_slice_ready;
    logic [CW-1:0]                  MtrxC_slice_data;

    typedef struct {
        logic [CW-1:0] data;
        logic          done;
    } expT;

    expT sb[$];
    expT expRow;
    int  checks = 0;
    int  errors = 0;

    logic [SYSTOLIC_DATA_WIDTH-1:0] idA[4], idB[4], sgA[4], sgB[4];
    logic [CW-1:0]                  sgRow;
    int                             lat;

    systolic_array_v1 dut (
        .s_clk             (s_clk),
        .s_rst             (s_rst),
        .MtrxA_slice_valid (MtrxA_slice_valid),
        .MtrxA_slice_data  (MtrxA_slice_data),
        .MtrxA_slice_done  (MtrxA_slice_done),
        .MtrxA_slice_ready (MtrxA_slice_ready),
        .MtrxB_slice_valid (MtrxB_slice_valid),
        .MtrxB_slice_data  (MtrxB_slice_data),
        .MtrxB_slice_done  (MtrxB_slice_done),
        .MtrxB_slice_ready (MtrxB_slice_ready),
        .MtrxC_slice_valid (MtrxC_slice_valid),
        .MtrxC_slice_data  (MtrxC_slice_data),
        .MtrxC_slice_done  (MtrxC_slice_done),
        .MtrxC_slice_ready (MtrxC_slice_ready)
    );

    always #5 s_clk = ~s_clk;

    function automatic logic [SYSTOLIC_DATA_WIDTH-1:0] packSlice(input int e0, input int e1,
                                                                 input int e2, input int e3);
        return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    function automatic logic [CW-1:0] packRow(input int e0, input int e1, input int e2, input int e3);
        return {e3[19:0], e2[19:0], e1[19:0], e0[19:0]};
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic idleInputs();
        MtrxA_slice_valid = 1'b0;
        MtrxB_slice_valid = 1'b0;
        MtrxA_slice_done  = 1'b0;
        MtrxB_slice_done  = 1'b0;
        MtrxA_slice_data  = '0;
        MtrxB_slice_data  = '0;
    endtask

    task automatic pushRows(input logic [CW-1:0] r0, input logic [CW-1:0] r1,
                            input logic [CW-1:0] r2, input logic [CW-1:0] r3);
        sb.push_back('{data: r0, done: 1'b0});
        sb.push_back('{data: r1, done: 1'b0});
        sb.push_back('{data: r2, done: 1'b0});
        sb.push_back('{data: r3, done: 1'b1});
    endtask

    // Called just after a rising edge; presents one paired beat that fires on the next edge.
    task automatic beat(input logic [SYSTOLIC_DATA_WIDTH-1:0] a,
                        input logic [SYSTOLIC_DATA_WIDTH-1:0] b, input logic last);
        MtrxA_slice_valid = 1'b1;
        MtrxB_slice_valid = 1'b1;
        MtrxA_slice_data  = a;
        MtrxB_slice_data  = b;
        MtrxA_slice_done  = last;
        MtrxB_slice_done  = last;
        #1;
        check("ab_ready_load", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b11);
        @(posedge s_clk); #1;
        idleInputs();
    endtask

    task automatic gapBeat(input logic [SYSTOLIC_DATA_WIDTH-1:0] a,
                           input logic [SYSTOLIC_DATA_WIDTH-1:0] b, input logic last);
        MtrxA_slice_valid = 1'b1;
        MtrxA_slice_data  = a;
        MtrxA_slice_done  = last;
        #1;
        check("gap_a_only_ready", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b01);
        @(posedge s_clk); #1;
        idleInputs();
        @(posedge s_clk); #1;
        MtrxB_slice_valid = 1'b1;
        MtrxB_slice_data  = b;
        MtrxB_slice_done  = last;
        #1;
        check("gap_b_only_ready", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b10);
        @(posedge s_clk); #1;
        idleInputs();
        beat(a, b, last);
    endtask

    task automatic sendMatrix(input logic [SYSTOLIC_DATA_WIDTH-1:0] aCols[4],
                              input logic [SYSTOLIC_DATA_WIDTH-1:0] bRows[4], input int k);
        for (int kk = 0; kk < k; kk++) begin
            beat(aCols[kk], bRows[kk], kk == k - 1);
        end
    endtask

    // Counts rising edges from the final fire until C valid is seen.
    task automatic waitValid(output int n);
        n = 0;
        while (!MtrxC_slice_valid && n < 40) begin
            @(posedge s_clk); #1;
            n++;
        end
        if (!MtrxC_slice_valid) begin
            checks++;
            errors++;
            $display("FAIL c_valid_timeout: got valid=0 after %0d cycles required valid=1", n);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || MtrxC_slice_valid) && n < 60) begin
            @(posedge s_clk); #1;
            n++;
        end
        check("drain_to_idle", {sb.size() != 0, MtrxC_slice_valid}, 2'b00);
    endtask

    always @(negedge s_clk) begin
        if (!s_rst && MtrxC_slice_valid && MtrxC_slice_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL c_unexpected_row: got row %h required no row", MtrxC_slice_data);
            end else begin
                expRow = sb.pop_front();
                check("c_row_data", MtrxC_slice_data, expRow.data);
                check("c_row_done", MtrxC_slice_done, expRow.done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idleInputs();
        MtrxC_slice_ready = 1'b1;
        s_rst = 1'b1;
        idA = '{packSlice(1, 0, 0, 0), packSlice(0, 1, 0, 0), packSlice(0, 0, 1, 0), packSlice(0, 0, 0, 1)};
        idB = '{packSlice(1, 2, 3, 4), packSlice(5, 6, 7, 8), packSlice(9, 10, 11, 12), packSlice(13, 14, 15, 16)};
        sgA = '{packSlice(-1, -1, -1, -1), packSlice(-1, -1, -1, -1), packSlice(-1, -1, -1, -1), packSlice(-1, -1, -1, -1)};
        sgB = '{packSlice(127, 127, 127, 127), packSlice(127, 127, 127, 127), packSlice(127, 127, 127, 127), packSlice(127, 127, 127, 127)};
        sgRow = {4{20'hFFE04}};

        repeat (3) @(posedge s_clk); #1;
        check("rst_c_valid", MtrxC_slice_valid, 1'b0);
        check("rst_c_done", MtrxC_slice_done, 1'b0);
        check("rst_c_data", MtrxC_slice_data, '0);
        check("rst_ab_ready", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b00);
        s_rst = 1'b0;
        @(posedge s_clk); #1;

        // Identity A: C equals B, first row 2N cycles after final fire.
        pushRows(packRow(1, 2, 3, 4), packRow(5, 6, 7, 8), packRow(9, 10, 11, 12), packRow(13, 14, 15, 16));
        sendMatrix(idA, idB, 4);
        waitValid(lat);
        check("latency_identity", lat, 8);
        waitIdle();

        // K = 1
        pushRows(packRow(1, 1, 1, 1), packRow(2, 2, 2, 2), packRow(3, 3, 3, 3), packRow(4, 4, 4, 4));
        beat(packSlice(1, 2, 3, 4), packSlice(1, 1, 1, 1), 1'b1);
        waitValid(lat);
        check("latency_k1", lat, 8);
        waitIdle();

        // Gapped, staggered producers
        pushRows(packRow(1, 2, 3, 4), packRow(5, 6, 7, 8), packRow(9, 10, 11, 12), packRow(13, 14, 15, 16));
        for (int k = 0; k < 4; k++) gapBeat(idA[k], idB[k], k == 3);
        waitValid(lat);
        waitIdle();

        // Signed operands under output backpressure
        MtrxC_slice_ready = 1'b0;
        pushRows(sgRow, sgRow, sgRow, sgRow);
        sendMatrix(sgA, sgB, 4);
        waitValid(lat);
        for (int c = 0; c < 6; c++) begin
            MtrxA_slice_valid = 1'b1;
            MtrxB_slice_valid = 1'b1;
            MtrxA_slice_data  = packSlice(5, 5, 5, 5);
            MtrxB_slice_data  = packSlice(5, 5, 5, 5);
            MtrxA_slice_done  = 1'b1;
            #1;
            check("bp_c_valid", MtrxC_slice_valid, 1'b1);
            check("bp_row0_data", MtrxC_slice_data, sgRow);
            check("bp_row0_done", MtrxC_slice_done, 1'b0);
            check("bp_ab_ready", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b00);
            @(posedge s_clk); #1;
        end
        idleInputs();
        MtrxC_slice_ready = 1'b1;
        repeat (4) @(posedge s_clk);
        #1;
        check("bp_rows_drained", sb.size(), 0);
        check("bp_c_valid_after", MtrxC_slice_valid, 1'b0);
        MtrxA_slice_valid = 1'b1;
        MtrxB_slice_valid = 1'b1;
        #1;
        check("bp_load_resumed", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b11);
        idleInputs();
        #1;

        // Abort after two beats, then a clean identity run
        @(posedge s_clk); #1;
        beat(packSlice(9, 9, 9, 9), packSlice(9, 9, 9, 9), 1'b0);
        beat(packSlice(7, 7, 7, 7), packSlice(7, 7, 7, 7), 1'b0);
        s_rst = 1'b1;
        #1;
        check("mid_rst_c_valid", MtrxC_slice_valid, 1'b0);
        check("mid_rst_c_data", MtrxC_slice_data, '0);
        check("mid_rst_ab_ready", {MtrxA_slice_ready, MtrxB_slice_ready}, 2'b00);
        @(posedge s_clk); #1;
        s_rst = 1'b0;
        @(posedge s_clk); #1;
        pushRows(packRow(1, 2, 3, 4), packRow(5, 6, 7, 8), packRow(9, 10, 11, 12), packRow(13, 14, 15, 16));
        sendMatrix(idA, idB, 4);
        waitValid(lat);
        check("latency_after_rst", lat, 8);
        waitIdle();

        check("sb_empty_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array_v1.md
Name: systolic_array_v1

Overview:
- Output-stationary N×N signed integer systolic matrix multiplier computing C = A·B, where A is N×K, B is K×N and K is set by the stream length.
- A arrives as a stream of columns and B as a stream of rows over valid/ready/done slice interfaces.
- Finished C is emitted row by row on a third slice interface.
- Sits between the slice fetch/generator logic (data_gen in the bench) and downstream result consumers in the transformer datapath.

Parameters:
- ARRAY_N, 4, array dimension N (PEs per side; elements per slice).
- ELEM_W, 8, signed two's-complement width of each A/B element.
- ACC_W, 20, signed accumulator width; also the width of each C element.
- SYSTOLIC_DATA_WIDTH, ARRAY_N*ELEM_W (32), A/B slice bus width (codebase macro).

Ports:
- s_clk  in  1  clock, rising edge.
- s_rst  in  1  asynchronous active-high reset.
- MtrxA_slice_valid  in  1  A column beat valid.
- MtrxA_slice_data  in  SYSTOLIC_DATA_WIDTH  A column k; element for row i at bits [i*ELEM_W +: ELEM_W].
- MtrxA_slice_done  in  1  marks the last A column (k = K-1).
- MtrxA_slice_ready  out  1  A beat accepted when valid&ready.
- MtrxB_slice_valid  in  1  B row beat valid.
- MtrxB_slice_data  in  SYSTOLIC_DATA_WIDTH  B row k; element for column j at bits [j*ELEM_W +: ELEM_W].
- MtrxB_slice_done  in  1  last B row.
- MtrxB_slice_ready  out  1  B beat accepted.
- MtrxC_slice_valid  out  1  C row valid.
- MtrxC_slice_data  out  ARRAY_N*ACC_W  C row r; element for column j at bits [j*ACC_W +: ACC_W].
- MtrxC_slice_done  out  1  high with the last C row (r = N-1).
- MtrxC_slice_ready  in  1  consumer accepts the C row.

Behaviour:
- Clock is s_clk; s_rst is asynchronous, active-high. Reset clears all outputs to 0, accumulators and skew/pipeline registers to 0, counters to 0, and sets state LOAD. Reset mid-operation discards the partial product.
- States:
  - LOAD: A/B beats accepted.
  - DRAIN: pipeline flush.
  - OUTPUT: C rows emitted.
- Handshake:
  - MtrxA_slice_ready = (state==LOAD) & MtrxB_slice_valid.
  - MtrxB_slice_ready = (state==LOAD) & MtrxA_slice_valid.
  - A and B beats therefore always transfer together. fire = LOAD & both valid.
- Feed: on fire, A element i enters row i's skew line, delayed i cycles, and B element j enters column j's skew line, delayed j cycles. On non-fire cycles zeros are injected, so input gaps are harmless.
- PE(i,j) each cycle:
  - a passes right and b passes down through registers.
  - acc += sign-extended a*b, wrapping modulo 2^ACC_W with no saturation.
- LOAD→DRAIN: on a fire with MtrxA_slice_done=1. MtrxB_slice_done is ignored; mismatched done is the producer's error.
- DRAIN: counts 2N-1 cycles, then moves to OUTPUT. The first MtrxC_slice_valid rises exactly 2N cycles after the final fire edge.
- OUTPUT:
  - Data is the row-r accumulators, r = 0..N-1, held stable while valid & !ready.
  - Row r advances on valid&ready.
  - MtrxC_slice_done=1 with row N-1.
  - After that transfer, accumulators clear and state returns to LOAD on the next cycle; A/B ready can reassert there.
- MtrxC_slice_ready=0 indefinitely: array holds row 0 valid forever and never accepts A/B.
- K=1 is legal (single beat with done).
- The next matrix cannot overlap the current DRAIN/OUTPUT.

Decomposition:
- Shared package/header: ARRAY_N, ELEM_W, ACC_W, SYSTOLIC_DATA_WIDTH and state encodings (LOAD/DRAIN/OUTPUT).
- One sub-module, systolic_pe: registered a/b pass-through plus MAC accumulator with synchronous clear. The top module instantiates an N×N grid of it and adds the skew lines, FSM and output mux.

Test Plan:
- Identity: K=4, A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} → C rows equal B rows; done on row 3; first C valid 8 cycles after last fire.
- K=1: A column {1,2,3,4}, B row {1,1,1,1} with done → C row i = {i+1,i+1,i+1,i+1}.
- Signed: K=4, all A=-1, all B=127 → every C element = -508 (0xFFE04 in 20 bits).
- Gaps: A valid on alternate cycles, B valid 2 cycles late → ready low while the partner is invalid; result identical to the identity test.
- Backpressure: MtrxC_slice_ready=0 → C valid stays 1 with row 0 stable, A/B ready stay 0. Release ready for 4 cycles → rows 0..3 transfer, then LOAD resumes.
- Reset mid-LOAD after 2 beats → all outputs 0, state LOAD; next full identity run is correct, with no residue from the aborted run.
